// File: rtl/pll_lock_sequencer_pkg.sv
// State encoding, default timing constants and a helper for the sequencer timer width.
// Shared by the sequencer top; holds no logic.
package pll_lock_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PLL_RST   = 3'd1,
    WAIT_LOCK = 3'd2,
    SETTLE    = 3'd3,
    RUN       = 3'd4,
    FAULT     = 3'd5
  } state_t;

  localparam int unsigned DEF_RST_CYCLES    = 64;
  localparam int unsigned DEF_LOCK_TIMEOUT  = 65536;
  localparam int unsigned DEF_SETTLE_CYCLES = 1024;
  localparam int unsigned DEF_MAX_RETRIES   = 4;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync_bit.sv
// Two-flop synchronizer with async active-low clear; 2 clk cycles latency.
// No flow control: samples every cycle.
module pll_lock_sequencer_sync_bit (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses PLL reset, waits for lock with timeout/retry, settles, releases PHY reset.
// Outputs are registered and follow the state register; enable=0 overrides everything next cycle.
module pll_lock_sequencer
  import pll_lock_sequencer_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned MAX_RETRIES   = DEF_MAX_RETRIES
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       pll_locked,
  output logic       pll_reset,
  output logic       phy_reset,
  output logic       ready,
  output logic       fault,
  output logic [7:0] retry_count,
  output logic [7:0] lock_loss_count,
  output logic [2:0] state
);

  localparam int unsigned TMAX = max3(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES);
  localparam int          TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] RST_LAST    = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LAST   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_TOP   = TW'(TMAX);
  localparam logic [7:0]    RETRY_LIMIT = 8'(MAX_RETRIES);

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    retry_q, retry_d;
  logic [7:0]    loss_q, loss_d;
  logic          pll_reset_q, pll_reset_d;
  logic          phy_reset_q, phy_reset_d;
  logic          ready_q, ready_d;
  logic          fault_q, fault_d;
  logic          locked_s;
  logic          fail;

  pll_lock_sequencer_sync_bit u_lock_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      pll_reset_q <= 1'b1;
      phy_reset_q <= 1'b1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      pll_reset_q <= pll_reset_d;
      phy_reset_q <= phy_reset_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    fail    = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      retry_d = '0;
    end else begin
      case (state_q)
        IDLE:      state_d = PLL_RST;
        PLL_RST:   if (timer_q == RST_LAST) state_d = WAIT_LOCK;
        // lock outranks a timeout landing in the same cycle
        WAIT_LOCK: begin
          if (locked_s)                    state_d = SETTLE;
          else if (timer_q == LOCK_LAST)   fail    = 1'b1;
        end
        SETTLE: begin
          if (!locked_s)                   fail    = 1'b1;
          else if (timer_q == SETTLE_LAST) state_d = RUN;
        end
        RUN: begin
          if (!locked_s) begin
            state_d = PLL_RST;
            loss_d  = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
          end
        end
        FAULT:     state_d = FAULT;
        default:   state_d = IDLE;
      endcase
      if (fail) begin
        retry_d = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
        state_d = (retry_d == RETRY_LIMIT) ? FAULT : PLL_RST;
      end
      if (state_d == RUN && state_q != RUN) retry_d = '0;
    end
    // one timer serves every state; it restarts at zero on each transition
    if (state_d != state_q)       timer_d = '0;
    else if (timer_q == TIMER_TOP) timer_d = timer_q;
    else                           timer_d = timer_q + TW'(1);
  end

  always_comb begin
    pll_reset_d = (state_d == IDLE) || (state_d == PLL_RST) || (state_d == FAULT);
    phy_reset_d = (state_d != RUN);
    ready_d     = (state_d == RUN);
    fault_d     = (state_d == FAULT);
  end

  assign pll_reset       = pll_reset_q;
  assign phy_reset       = phy_reset_q;
  assign ready           = ready_q;
  assign fault           = fault_q;
  assign retry_count     = retry_q;
  assign lock_loss_count = loss_q;
  assign state           = state_q;

endmodule
